// File: rtl/fdiv_pipe.sv
// fdiv_pipe: pipelined IEEE-754 single-precision divide y = x1 / x2 (reciprocal via finv, then multiply).
// Latency 3 cycles, one result per cycle; bubbles flow through, subnormals read as zero.
// Backpressure: stall = valid_out & ~ready_out freezes all stages, ready_in = ~stall.
// Optional FDIV_STICKY_FLAGS_EN adds clr_flags / sticky_ovf / sticky_udf.

// finv: combinational reciprocal r = 1/x of a normal single; the mantissa is rounded to nearest.
// Latency 0; no handshake.
// Results whose exponent would drop to 0 or below are flushed to signed zero.
module finv (
  input  logic [31:0] x,
  output logic [31:0] r
);
  // 2^48 / m gives 25 significant quotient bits; the lowest one rounds the 24-bit result.
  localparam logic [48:0] RECIP_NUM = 49'h1_0000_0000_0000;

  logic              pow2;
  logic [24:0]       qf;
  logic [22:0]       q;
  logic signed [9:0] ee;

  assign pow2 = (x[22:0] == 23'd0);
  assign qf   = 25'(RECIP_NUM / {25'd0, 1'b1, x[22:0]});
  assign q    = 23'((qf + 25'd1) >> 1);
  // An exact power of two keeps mantissa 1.0; any other mantissa lands in (0.5,1) and loses one exponent.
  assign ee   = (pow2 ? 10'sd254 : 10'sd253) - $signed({2'b00, x[30:23]});

  // Pack the reciprocal, flushing to zero when the exponent runs out of range.
  always_comb begin
    r = {x[31], 31'd0};
    if (ee > 10'sd0) begin
      r = {x[31], ee[7:0], (pow2 ? 23'd0 : q)};
    end
  end
endmodule

module fdiv_pipe #(
  parameter int LAT_STAGES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic        valid_in,
  output logic        ready_in,
  output logic [31:0] y,
  output logic        valid_out,
  input  logic        ready_out,
  output logic        overflow,
  output logic        underflow
`ifdef FDIV_STICKY_FLAGS_EN
  ,
  input  logic        clr_flags,
  output logic        sticky_ovf,
  output logic        sticky_udf
`endif
);
  logic [LAT_STAGES-1:0] stg_vld;
  logic                  stall;

  logic [31:0] r;
  logic        s1_s, s1_z, s1_dz;
  logic [7:0]  s1_e1, s1_er;
  logic [23:0] s1_m1, s1_mr;

  logic              s2_s, s2_z, s2_dz;
  logic [47:0]       s2_p;
  logic signed [9:0] s2_esum;

  logic [22:0]       mant, mant_rnd;
  logic              guard, sticky, rnd_up, carry;
  logic signed [9:0] e_adj, e_fin;
  logic [31:0]       y_nxt;
  logic              ovf_nxt, udf_nxt;

  assign valid_out = stg_vld[LAT_STAGES-1];
  assign stall     = valid_out & ~ready_out;
  assign ready_in  = ~stall;

  finv u_finv (
    .x (x2),
    .r (r)
  );

  // Stage valids shift together; a stall freezes them, bubbles enter when no input transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_vld <= '0;
    end else if (!stall) begin
      stg_vld <= {stg_vld[LAT_STAGES-2:0], valid_in & ready_in};
    end
  end

  // S1: capture dividend fields and the reciprocal of the divisor.
  always_ff @(posedge clk) begin
    if (!stall) begin
      s1_s  <= x1[31] ^ r[31];
      s1_e1 <= x1[30:23];
      s1_m1 <= {1'b1, x1[22:0]};
      s1_er <= r[30:23];
      s1_mr <= {1'b1, r[22:0]};
      s1_z  <= (x1[30:23] == 8'd0);
      s1_dz <= (x2[30:23] == 8'd0);
    end
  end

  // S2: full mantissa product and the unnormalised biased exponent.
  always_ff @(posedge clk) begin
    if (!stall) begin
      s2_s    <= s1_s;
      s2_z    <= s1_z;
      s2_dz   <= s1_dz;
      s2_p    <= s1_m1 * s1_mr;
      s2_esum <= $signed({2'b00, s1_e1}) + $signed({2'b00, s1_er}) - 10'sd127;
    end
  end

  // S3 combinational: normalise, round to nearest-even, then apply the special-case priority.
  always_comb begin
    mant   = s2_p[45:23];
    guard  = s2_p[22];
    sticky = |s2_p[21:0];
    e_adj  = s2_esum;
    if (s2_p[47]) begin
      mant   = s2_p[46:24];
      guard  = s2_p[23];
      sticky = |s2_p[22:0];
      e_adj  = s2_esum + 10'sd1;
    end
    rnd_up            = guard & (sticky | mant[0]);
    {carry, mant_rnd} = {1'b0, mant} + {23'd0, rnd_up};
    e_fin             = carry ? (e_adj + 10'sd1) : e_adj;

    y_nxt   = {s2_s, e_fin[7:0], mant_rnd};
    ovf_nxt = 1'b0;
    udf_nxt = 1'b0;
    if (s2_dz) begin
      y_nxt   = {s2_s, 8'hFF, 23'd0};
      ovf_nxt = 1'b1;
    end else if (s2_z) begin
      y_nxt = {s2_s, 31'd0};
    end else if (e_fin >= 10'sd255) begin
      y_nxt   = {s2_s, 8'hFF, 23'd0};
      ovf_nxt = 1'b1;
    end else if (e_fin <= 10'sd0) begin
      y_nxt   = {s2_s, 31'd0};
      udf_nxt = 1'b1;
    end
  end

  // S3 output register: result and flags held together while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      y         <= 32'd0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (!stall) begin
      y         <= y_nxt;
      overflow  <= ovf_nxt;
      underflow <= udf_nxt;
    end
  end

`ifdef FDIV_STICKY_FLAGS_EN
  logic out_xfer;
  assign out_xfer = valid_out & ready_out;

  // Sticky flags: set by a flagged output transfer, cleared by clr_flags; set wins over clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_ovf <= 1'b0;
      sticky_udf <= 1'b0;
    end else begin
      if (out_xfer && overflow) begin
        sticky_ovf <= 1'b1;
      end else if (clr_flags) begin
        sticky_ovf <= 1'b0;
      end
      if (out_xfer && underflow) begin
        sticky_udf <= 1'b1;
      end else if (clr_flags) begin
        sticky_udf <= 1'b0;
      end
    end
  end
`endif
endmodule
